// File: rtl/apb_master_bridge_if.sv
// Bundle of the bridge's command port, APB bus, response port and debug taps.
// The master modport is the bridge's view; slave is the environment's view.
//
// Handshakes:
//   cmd: a command transfers on a rising clk edge where cmd_valid && cmd_ready.
//        The requester holds cmd_valid and a stable payload until that edge.
//        cmd_ready depends only on FIFO occupancy, never on cmd_valid.
//   rsp: rsp_valid is a single-cycle pulse with no ready; the consumer must
//        take every response in the cycle it appears.
interface apb_master_bridge_if #(
    parameter int addrWidth = 32,
    parameter int dataWidth = 32,
    parameter int fifoDepth = 4
);
    localparam int CntW = $clog2(fifoDepth) + 1;

    // command port
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [addrWidth-1:0] cmd_addr;
    logic [dataWidth-1:0] cmd_wdata;

    // APB bus
    logic [addrWidth-1:0] paddr;
    logic                 pwrite;
    logic                 psel;
    logic                 penable;
    logic [dataWidth-1:0] pwdata;
    logic [dataWidth-1:0] prdata;

    // response port and status
    logic                 rsp_valid;
    logic                 rsp_write;
    logic [dataWidth-1:0] rsp_rdata;
    logic                 busy;

    // debug taps: FSM state (0 IDLE, 1 SETUP, 2 ENABLE, 3 CAPTURE) and FIFO count
    logic [1:0]           dbg_state;
    logic [CntW-1:0]      dbg_count;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata,
        output cmd_ready, paddr, pwrite, psel, penable, pwdata,
        output rsp_valid, rsp_write, rsp_rdata, busy, dbg_state, dbg_count
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata,
        input  cmd_ready, paddr, pwrite, psel, penable, pwdata,
        input  rsp_valid, rsp_write, rsp_rdata, busy, dbg_state, dbg_count
    );
endinterface

// File: rtl/apb_master_bridge.sv
// APB requester: buffers read/write commands in a small circular FIFO and
// plays each one out as SETUP/ENABLE phases. Writes take 2 bus cycles, reads
// take 3 (an extra CAPTURE cycle to pick up the slave's registered prdata).
// One response pulse is produced per command, in command order.
module apb_master_bridge #(
    parameter int addrWidth = 32,
    parameter int dataWidth = 32,
    parameter int fifoDepth = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    apb_master_bridge_if.master   bus
);
    localparam int PtrW = $clog2(fifoDepth);
    localparam int CntW = PtrW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ENABLE  = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t               state_q, state_d;

    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]      count_q, count_d;

    logic [addrWidth-1:0] addr_mem  [fifoDepth];
    logic                 write_mem [fifoDepth];
    logic [dataWidth-1:0] wdata_mem [fifoDepth];

    logic [addrWidth-1:0] paddr_q;
    logic                 pwrite_q;
    logic                 psel_q;
    logic                 penable_q;
    logic [dataWidth-1:0] pwdata_q;
    logic                 rsp_valid_q;
    logic                 rsp_write_q;
    logic [dataWidth-1:0] rsp_rdata_q;
    logic                 busy_q;

    logic                 fifo_nonempty;
    logic                 push;
    logic                 pop;

    assign fifo_nonempty = (count_q != '0);
    assign bus.cmd_ready = (count_q < CntW'(fifoDepth));
    assign push          = bus.cmd_valid && bus.cmd_ready;
    // SETUP is only ever entered by taking the FIFO head
    assign pop           = (state_d == SETUP);

    // Next FSM state; a write finishing in ENABLE chains straight into SETUP
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = fifo_nonempty ? SETUP : IDLE;
            SETUP:   state_d = ENABLE;
            ENABLE:  state_d = pwrite_q ? (fifo_nonempty ? SETUP : IDLE) : CAPTURE;
            CAPTURE: state_d = fifo_nonempty ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next FIFO pointers and occupancy; simultaneous push/pop keeps the count
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q]  <= bus.cmd_addr;
            write_mem[wr_ptr_q] <= bus.cmd_write;
            wdata_mem[wr_ptr_q] <= bus.cmd_wdata;
        end
    end

    // FIFO pointers and count; reset discards everything queued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FSM with registered bus, response and busy outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            psel_q    <= (state_d == SETUP) || (state_d == ENABLE);
            penable_q <= (state_d == ENABLE);

            // address/direction/data change only when a new transfer starts
            if (pop) begin
                paddr_q  <= addr_mem[rd_ptr_q];
                pwrite_q <= write_mem[rd_ptr_q];
                pwdata_q <= wdata_mem[rd_ptr_q];
            end

            rsp_valid_q <= 1'b0;
            if (state_q == ENABLE && pwrite_q) begin
                rsp_valid_q <= 1'b1;
                rsp_write_q <= 1'b1;
                rsp_rdata_q <= '0;
            end else if (state_q == CAPTURE) begin
                rsp_valid_q <= 1'b1;
                rsp_write_q <= 1'b0;
                rsp_rdata_q <= bus.prdata;
            end

            busy_q <= (state_q != IDLE) || fifo_nonempty;
        end
    end

    assign bus.paddr     = paddr_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.busy      = busy_q;
    assign bus.dbg_state = state_q;
    assign bus.dbg_count = count_q;
endmodule
